// File: rtl/kf_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : kf_pkg                                                       |
// | Description : Shared word type, header constant and framer state encoding |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package kf_pkg;

    localparam int KF_WIDTH = 16;
    localparam logic [KF_WIDTH-1:0] KF_HEADER = 16'hA55A;

    typedef logic [KF_WIDTH-1:0] kf_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/kf_state_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : kf_state_tx                                                  |
// | Description : Captures the filter state vector and streams it as a framed |
// |               valid/ready word sequence. Define KF_TX_CHECKSUM_EN to add   |
// |               a trailing modulo-2^WIDTH checksum word.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module kf_state_tx
    import kf_pkg::*;
#(
    parameter int               N_STATES = 4,
    parameter int               WIDTH    = KF_WIDTH,
    parameter logic [WIDTH-1:0] HEADER   = KF_HEADER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] State0,
    input  logic [WIDTH-1:0] State1,
    input  logic [WIDTH-1:0] State2,
    input  logic [WIDTH-1:0] State3,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       frame_count
);

    localparam int IDXW = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_STATES - 1);

    tx_state_t        state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] words_q [N_STATES];
    logic [WIDTH-1:0] words_d [N_STATES];
    logic             overrun_q, overrun_d;
    logic [7:0]       count_q, count_d;
`ifdef KF_TX_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
`endif

    logic w_xfer;
    logic w_final;
    logic w_start;

    assign w_xfer  = m_valid && m_ready;
    assign w_final = w_xfer && m_last;
    // A capture coincident with the final beat chains straight into the next frame.
    assign w_start = capture && ((state_q == IDLE) || w_final);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            count_q   <= 8'd0;
            for (int i = 0; i < N_STATES; i++) begin
                words_q[i] <= '0;
            end
`ifdef KF_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            words_q   <= words_d;
`ifdef KF_TX_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        words_d   = words_q;
`ifdef KF_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        if (capture && !w_start) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            HDR: begin
                if (w_xfer) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (w_xfer) begin
`ifdef KF_TX_CHECKSUM_EN
                    csum_d = csum_q + words_q[idx_q];
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef KF_TX_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
                        count_d = count_q + 8'd1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    state_d = IDLE;
                    count_d = count_q + 8'd1;
                end
            end
            default: ;
        endcase

        if (w_start) begin
            state_d = HDR;
            idx_d   = '0;
`ifdef KF_TX_CHECKSUM_EN
            csum_d  = HEADER;
`endif
            // Words beyond the four state ports are sent as zero.
            for (int i = 0; i < N_STATES; i++) begin
                case (i)
                    0:       words_d[i] = State0;
                    1:       words_d[i] = State1;
                    2:       words_d[i] = State2;
                    3:       words_d[i] = State3;
                    default: words_d[i] = '0;
                endcase
            end
        end
    end

    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        unique case (state_q)
            HDR:  m_data = HEADER;
            DATA: begin
                m_data = words_q[idx_q];
`ifndef KF_TX_CHECKSUM_EN
                m_last = (idx_q == LAST_IDX);
`endif
            end
`ifdef KF_TX_CHECKSUM_EN
            CSUM: begin
                m_data = csum_q;
                m_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign m_valid     = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign frame_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_kf_state_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_kf_state_tx                                               |
// | Description : Directed self-checking bench for kf_state_tx                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kf_state_tx;

    logic        clk;
    logic        reset;
    logic        capture;
    logic [15:0] State0, State1, State2, State3;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];

    kf_state_tx dut (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .State0      (State0),
        .State1      (State1),
        .State2      (State2),
        .State3      (State3),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame: header, four data words and, when enabled, their 16-bit sum.
    task automatic make_frame(input logic [15:0] a, b, c, d);
        logic [15:0] s;
        exp_q.delete();
        exp_q.push_back(16'hA55A);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
`ifdef KF_TX_CHECKSUM_EN
        s = 16'hA55A + a + b + c + d;
        exp_q.push_back(s);
`endif
    endtask

    // Pulse capture for one cycle, then confirm the header appears one cycle later.
    task automatic start_frame(input logic [15:0] a, b, c, d);
        @(negedge clk);
        m_ready = 1'b0;
        capture = 1'b1;
        State0 = a; State1 = b; State2 = c; State3 = d;
        make_frame(a, b, c, d);
        @(negedge clk);
        capture = 1'b0;
        chk("lat_valid", {31'd0, m_valid}, 32'd1);
        chk("lat_hdr",   {16'd0, m_data},  32'h0000A55A);
        chk("lat_busy",  {31'd0, busy},    32'd1);
    endtask

    // Drain exp_q. bp selects the 1,0,0,1 ready pattern; chain raises capture on the final beat.
    task automatic recv_frame(input bit bp, input bit chain, input logic [15:0] n0, n1, n2, n3);
        int          k = 0;
        int          cyc = 0;
        int          len;
        bit          prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        len = exp_q.size();
        while (k < len && cyc < 100) begin
            @(negedge clk);
            capture = 1'b0;
            m_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            chk("mid_valid", {31'd0, m_valid}, 32'd1);
            if (prev_stall) chk("stall_hold", {16'd0, m_data}, {16'd0, prev_data});
            if (m_valid && m_ready) begin
                chk("word", {16'd0, m_data}, {16'd0, exp_q[k]});
                chk("last", {31'd0, m_last}, {31'd0, (k == len - 1)});
                if (chain && k == len - 1) begin
                    capture = 1'b1;
                    State0 = n0; State1 = n1; State2 = n2; State3 = n3;
                end
                k++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            cyc++;
        end
        if (k < len) chk("frame_timeout", k, len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid",   {31'd0, m_valid},    32'd0);
        chk("rst_last",    {31'd0, m_last},     32'd0);
        chk("rst_data",    {16'd0, m_data},     32'd0);
        chk("rst_busy",    {31'd0, busy},       32'd0);
        chk("rst_overrun", {31'd0, overrun},    32'd0);
        chk("rst_count",   {24'd0, frame_count}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; capture = 1'b0; m_ready = 1'b0;
        State0 = '0; State1 = '0; State2 = '0; State3 = '0;
        do_reset();

        // Basic frame
        start_frame(16'h0001, 16'h0002, 16'hFFFF, 16'h8000);
        recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("basic_idle_valid", {31'd0, m_valid}, 32'd0);
        chk("basic_idle_busy",  {31'd0, busy},    32'd0);
        chk("basic_count",      {24'd0, frame_count}, 32'd1);

        // Backpressure
        start_frame(16'h0001, 16'h0002, 16'hFFFF, 16'h8000);
        recv_frame(1'b1, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp_count", {24'd0, frame_count}, 32'd2);

        // Overrun: second capture while the first frame is stalled in HDR
        start_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        @(negedge clk);
        capture = 1'b1;
        State0 = 16'h1234;
        recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("ovr_flag",  {31'd0, overrun},     32'd1);
        chk("ovr_count", {24'd0, frame_count}, 32'd3);
        repeat (3) @(negedge clk);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        do_reset();

        // Back-to-back: capture on the final handshake
        start_frame(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        recv_frame(1'b0, 1'b1, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        @(negedge clk);
        capture = 1'b0;
        m_ready = 1'b0;
        chk("b2b_valid",   {31'd0, m_valid},     32'd1);
        chk("b2b_hdr",     {16'd0, m_data},      32'h0000A55A);
        chk("b2b_overrun", {31'd0, overrun},     32'd0);
        chk("b2b_count1",  {24'd0, frame_count}, 32'd1);
        make_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("b2b_count2", {24'd0, frame_count}, 32'd2);

        // Reset mid-frame at DATA index 2
        start_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_data2", {16'd0, m_data}, 32'h00000C0C);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid},     32'd0);
        chk("mid_rst_count", {24'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_ready = 1'b0;
        start_frame(16'h1357, 16'h2468, 16'h9BDF, 16'hACE0);
        recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("fresh_count", {24'd0, frame_count}, 32'd1);

        // Wrap: 254 more frames reach 255, one more returns to 0
        for (int f = 0; f < 254; f++) begin
            start_frame(16'(f), 16'(f + 1), 16'(f + 2), 16'(f + 3));
            recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        end
        @(negedge clk);
        m_ready = 1'b0;
        chk("wrap_255", {24'd0, frame_count}, 32'd255);
        start_frame(16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA);
        recv_frame(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("wrap_0", {24'd0, frame_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
